// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared types and helpers for the programmable sequence detector
package seq_detect_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } det_state_t;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam int LEN_W = len_w(8);

  // Zero length is meaningless, so it becomes 1; oversize lengths pin to max_len.
  function automatic logic [31:0] clamp_len(input logic [31:0] raw, input int max_len);
    if (raw == 32'd0)
      return 32'd1;
    else if (raw > 32'(max_len))
      return 32'(max_len);
    else
      return raw;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear taking priority over increment
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - runtime-programmable serial pattern detector; SEQ_DETECT_MASK_EN adds cfg_mask
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int                MAX_LEN         = 8,
  parameter int                CNT_W           = 16,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(8'b0000_1011),
  parameter int                DEFAULT_LEN     = 4,
  parameter logic              DEFAULT_OVERLAP = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic                           in_bit,
  input  logic                           cfg_we,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
`ifdef SEQ_DETECT_MASK_EN
  input  logic [MAX_LEN-1:0]             cfg_mask,
`endif
  input  logic                           cnt_clr,
  output logic                           match,
  output logic [CNT_W-1:0]               match_count,
  output logic [$clog2(MAX_LEN+1)-1:0]   cur_len
);

  localparam int L_W = len_w(MAX_LEN);
  localparam logic [L_W-1:0] RST_LEN = L_W'(clamp_len(32'(DEFAULT_LEN), MAX_LEN));

  logic [MAX_LEN-1:0] pattern;
  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] mask;
  logic [L_W-1:0]     len;
  logic [L_W-1:0]     fill;
  logic [L_W-1:0]     fill_next;
  logic [L_W:0]       fill_inc;
  logic               overlap;
  logic               cmp_en;
  logic               cmp_eq;
  logic               match_hit;
  det_state_t         state;
  det_state_t         state_next;

  assign hist_next = {hist[MAX_LEN-2:0], in_bit};
  assign fill_inc  = {1'b0, fill} + 1'b1;
  assign cur_len   = len;

`ifdef SEQ_DETECT_MASK_EN
  always_ff @(posedge clk) begin
    if (rst)
      mask <= '1;
    else if (cfg_we)
      mask <= cfg_mask;
  end
`else
  assign mask = '1;
`endif

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      len_mask[i] = (i < int'(len));
  end

  assign cmp_eq = (((hist_next ^ pattern) & mask & len_mask) == '0);

  // Compare only once the completing bit can fill the window.
  always_comb begin
    state_next = state;
    fill_next  = fill;
    cmp_en     = 1'b0;
    match_hit  = 1'b0;
    if (cfg_we) begin
      state_next = FILL;
      fill_next  = '0;
    end else if (in_valid) begin
      case (state)
        FILL:    cmp_en = (fill_inc == {1'b0, len});
        ARMED:   cmp_en = 1'b1;
        default: cmp_en = 1'b0;
      endcase
      match_hit = cmp_en && cmp_eq;
      if (match_hit && !overlap) begin
        fill_next  = '0;
        state_next = FILL;
      end else begin
        if (fill_inc <= {1'b0, len})
          fill_next = fill_inc[L_W-1:0];
        if (fill_inc >= {1'b0, len})
          state_next = ARMED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      fill  <= '0;
      match <= 1'b0;
    end else begin
      state <= state_next;
      fill  <= fill_next;
      match <= match_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern <= DEFAULT_PATTERN;
      len     <= RST_LEN;
      overlap <= DEFAULT_OVERLAP;
      hist    <= '0;
    end else if (cfg_we) begin
      pattern <= cfg_pattern;
      len     <= L_W'(clamp_len(32'(cfg_len), MAX_LEN));
      overlap <= cfg_overlap;
      hist    <= '0;
    end else if (in_valid) begin
      hist <= hist_next;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (match_hit),
    .clr   (cnt_clr),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed self-checking bench for seq_detect_param
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       cnt_clr;
  logic       match;
  logic [1:0] match_count;
  logic [3:0] cur_len;
`ifdef SEQ_DETECT_MASK_EN
  logic [7:0] cfg_mask;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  seq_detect_param #(
    .MAX_LEN(8),
    .CNT_W  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
`ifdef SEQ_DETECT_MASK_EN
    .cfg_mask   (cfg_mask),
`endif
    .cnt_clr    (cnt_clr),
    .match      (match),
    .match_count(match_count),
    .cur_len    (cur_len)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic b, input logic exp_match, input logic [1:0] exp_cnt, input string tag);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
    chk({tag, "_match"}, 32'(match), 32'(exp_match));
    chk({tag, "_cnt"}, 32'(match_count), 32'(exp_cnt));
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl, input logic [7:0] msk);
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cnt_clr     = 1'b1;
`ifdef SEQ_DETECT_MASK_EN
    cfg_mask    = msk;
`endif
    tick();
    cfg_we  = 1'b0;
    cnt_clr = 1'b0;
    chk("load_match", 32'(match), 32'd0);
    chk("load_cnt", 32'(match_count), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; cfg_we = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
`ifdef SEQ_DETECT_MASK_EN
    cfg_mask = '1;
`endif
    tick(); tick();
    rst = 1'b0;
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_cnt", 32'(match_count), 32'd0);
    chk("rst_len", 32'(cur_len), 32'd4);

    // Default 1011 overlapping: matches on bits 4 and 7.
    send(1, 0, 0, "ov_b1"); send(0, 0, 0, "ov_b2"); send(1, 0, 0, "ov_b3");
    send(1, 1, 1, "ov_b4"); send(0, 0, 1, "ov_b5"); send(1, 0, 1, "ov_b6");
    send(1, 1, 2, "ov_b7");
    tick();
    chk("ov_idle_match", 32'(match), 32'd0);

    // Non-overlapping: the second 1011 needs four fresh bits.
    load(8'b0000_1011, 4'd4, 1'b0, 8'hff);
    send(1, 0, 0, "no_b1"); send(0, 0, 0, "no_b2"); send(1, 0, 0, "no_b3");
    send(1, 1, 1, "no_b4"); send(0, 0, 1, "no_b5"); send(1, 0, 1, "no_b6");
    send(1, 0, 1, "no_b7");

    // Full-width pattern with two idle cycles between valid bits.
    load(8'b1100_1010, 4'd8, 1'b1, 8'hff);
    chk("len8", 32'(cur_len), 32'd8);
    begin
      logic [7:0] s;
      s = 8'b1100_1010;
      for (int i = 7; i >= 0; i--) begin
        send(s[i], (i == 0), (i == 0) ? 2'd1 : 2'd0, "gap_bit");
        tick(); chk("gap_idle1", 32'(match), 32'd0);
        tick(); chk("gap_idle2", 32'(match), 32'd0);
      end
    end

    // Length clamping.
    load(8'h01, 4'd12, 1'b1, 8'hff);
    chk("clamp_hi", 32'(cur_len), 32'd8);
    load(8'h01, 4'd0, 1'b1, 8'hff);
    chk("clamp_lo", 32'(cur_len), 32'd1);
    send(1, 1, 1, "l1_b1"); send(1, 1, 2, "l1_b2");
    send(0, 0, 2, "l1_b3"); send(1, 1, 3, "l1_b4");

    // 2-bit counter saturation, then clear coinciding with a match.
    load(8'h01, 4'd1, 1'b1, 8'hff);
    send(1, 1, 1, "sat1"); send(1, 1, 2, "sat2"); send(1, 1, 3, "sat3");
    send(1, 1, 3, "sat4"); send(1, 1, 3, "sat5");
    cnt_clr = 1'b1;
    send(1, 1, 0, "clr_hit");
    cnt_clr = 1'b0;

    // Reset mid-pattern discards history and restores defaults.
    load(8'b0000_1011, 4'd4, 1'b1, 8'hff);
    send(1, 0, 0, "rp_b1"); send(0, 0, 0, "rp_b2"); send(1, 0, 0, "rp_b3");
    rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rp_rst_match", 32'(match), 32'd0);
    chk("rp_rst_len", 32'(cur_len), 32'd4);
    send(1, 0, 0, "rp_after");
    send(1, 0, 0, "rp_f1"); send(0, 0, 0, "rp_f2"); send(1, 0, 0, "rp_f3");
    send(1, 1, 1, "rp_f4");

    // Config load mid-pattern; same-cycle valid bit is ignored.
    send(1, 0, 1, "cw_b1"); send(0, 0, 1, "cw_b2"); send(1, 0, 1, "cw_b3");
    cfg_we = 1'b1; cfg_pattern = 8'b0000_1011; cfg_len = 4'd4; cfg_overlap = 1'b1;
    in_valid = 1'b1; in_bit = 1'b1;
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    chk("cw_load_match", 32'(match), 32'd0);
    chk("cw_cnt_kept", 32'(match_count), 32'd1);
    send(1, 0, 1, "cw_after");

`ifdef SEQ_DETECT_MASK_EN
    load(8'b0000_1011, 4'd4, 1'b1, 8'b0000_1101);
    send(1, 0, 0, "mk_b1"); send(0, 0, 0, "mk_b2"); send(0, 0, 0, "mk_b3");
    send(1, 1, 1, "mk_b4");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
